// File: rtl/display_pkg.sv
// ============================================================================
//  display_pkg
//  Shared constants for the 8-digit common-anode 7-segment display driver.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F, dp off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

`default_nettype wire

// File: rtl/hex7seg_decode.sv
// ============================================================================
//  hex7seg_decode
//  Combinational 4-bit nibble to active-low segment pattern, dp forced off.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hex7seg_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    logic [7:0] pattern;

    assign pattern = HEX_SEG[nibble];
    assign seg     = {1'b1, pattern[6:0]};

endmodule

`default_nettype wire

// File: rtl/seg7_x16.sv
// ============================================================================
//  seg7_x16
//  Time-multiplexed 8-digit 7-segment driver: hex or raw segment mode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_x16
    import display_pkg::*;
#(
    parameter int DIV_BITS = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        disp_mode,
    input  logic [31:0] i_data,
    output logic [7:0]  disp_seg_o,
    output logic [7:0]  disp_an_o
);

    logic [31:0]         i_data_q;
    logic                mode_q;
    logic [DIV_BITS-1:0] div_cnt;
    logic [2:0]          scan_idx;

    logic [3:0] nibble;
    logic [7:0] raw_byte;
    logic [7:0] hex_seg;
    logic [7:0] seg_next;
    logic [7:0] an_next;

    assign nibble   = i_data_q[{scan_idx, 2'b00} +: 4];
    assign raw_byte = i_data_q[{scan_idx[1:0], 3'b000} +: 8];

    hex7seg_decode u_decode (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // Raw mode only has four bytes of data; the upper four digits stay blank.
    always_comb begin
        seg_next = hex_seg;
        if (mode_q) begin
            seg_next = scan_idx[2] ? SEG_BLANK : raw_byte;
        end
        an_next = ~(8'b1 << scan_idx);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_data_q   <= '0;
            mode_q     <= 1'b0;
            div_cnt    <= '0;
            scan_idx   <= '0;
            disp_seg_o <= SEG_BLANK;
            disp_an_o  <= AN_OFF;
        end else begin
            i_data_q   <= i_data;
            mode_q     <= disp_mode;
            div_cnt    <= div_cnt + 1'b1;
            if (&div_cnt) begin
                scan_idx <= scan_idx + 3'd1;
            end
            // Anode and segments share one register stage so they never disagree.
            disp_seg_o <= seg_next;
            disp_an_o  <= an_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_x16.sv
// ============================================================================
//  tb_seg7_x16
//  Self-checking bench for seg7_x16 with a cycle-count reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_x16;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        disp_mode = 1'b0;
    logic [31:0] i_data = '0;
    logic [7:0]  disp_seg_o;
    logic [7:0]  disp_an_o;

    int checks = 0;
    int failures = 0;

    // Reference model state: edges since reset release, and the inputs seen
    // at the previous edge (what the display shows one edge later).
    int          t = 0;
    logic [31:0] m_data = '0;
    logic        m_mode = 1'b0;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_x16 #(.DIV_BITS(DIV)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .disp_mode  (disp_mode),
        .i_data     (i_data),
        .disp_seg_o (disp_seg_o),
        .disp_an_o  (disp_an_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_seg(input logic [31:0] d, input logic m, input int dig);
        if (m) return (dig < 4) ? d[dig*8 +: 8] : 8'hFF;
        return hex_tab[d[dig*4 +: 4]];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // One clock edge: compute expectation from the model, then compare on the
    // following falling edge.
    task automatic step(input string tag);
        int          dig;
        logic [7:0]  e_an;
        logic [7:0]  e_seg;
        @(posedge clk);
        t++;
        dig   = ((t - 1) / (1 << DIV)) % 8;
        e_an  = ~(8'b1 << dig);
        e_seg = ref_seg(m_data, m_mode, dig);
        m_data = i_data;
        m_mode = disp_mode;
        @(negedge clk);
        check({tag, "_an"},  disp_an_o,  e_an);
        check({tag, "_seg"}, disp_seg_o, e_seg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_an",  disp_an_o,  8'hFF);
        check("async_rst_seg", disp_seg_o, 8'hFF);
        repeat (3) @(negedge clk);
        check("hold_rst_an",  disp_an_o,  8'hFF);
        check("hold_rst_seg", disp_seg_o, 8'hFF);
        rstn   = 1'b1;
        t      = 0;
        m_data = '0;
        m_mode = 1'b0;
    endtask

    initial begin
        // Reset with clock running, then the basic hex scan over one full frame
        // plus a wrap back to digit 0.
        i_data    = 32'h7654_3210;
        disp_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("init_rst_an",  disp_an_o,  8'hFF);
        check("init_rst_seg", disp_seg_o, 8'hFF);
        do_reset();
        repeat (8 * (1 << DIV) + 4) step("hex_lo");

        // Upper hex digits; also asserts reset mid-frame.
        i_data = 32'hFEDC_BA98;
        repeat (5) step("hex_hi_pre");
        do_reset();
        repeat (8 * (1 << DIV)) step("hex_hi");

        // Raw segment mode.
        disp_mode = 1'b1;
        i_data    = 32'h7F00_AA55;
        do_reset();
        repeat (8 * (1 << DIV) + 2) step("raw");

        // Data-change latency inside digit 0.
        disp_mode = 1'b0;
        i_data    = 32'h0000_0000;
        do_reset();
        step("lat0");
        i_data = 32'h0000_0001;
        step("lat1");
        step("lat2");
        check("lat_seg_f9", disp_seg_o, 8'hF9);
        check("lat_an_fe",  disp_an_o,  8'hFE);

        // Randomized data and mode changes at arbitrary points in the scan.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) i_data = $urandom;
            if ($urandom_range(0, 15) == 0) disp_mode = ~disp_mode;
            step("rand");
            if (i == 150) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_x16.md
# seg7_x16

Time-multiplexed driver for an 8-digit, common-anode 7-segment display. It takes a 32-bit value from the CPU debug mux and shows it as eight hexadecimal digits. In raw mode it drives segment patterns directly instead. It sits at the board top level between the data-select logic and the display pins.

## Interface
- DIV_BITS, default 15: prescaler width. The scan advances every 2^DIV_BITS clk cycles.
- clk  in  1  system clock (board oscillator).
- rstn  in  1  reset; asynchronous, active-low.
- disp_mode  in  1  0 = hex mode, 1 = raw segment mode.
- i_data  in  32  value to display.
- disp_seg_o  out  8  segment drive, active-low. Bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- disp_an_o  out  8  digit enables, active-low, one-hot. Bit 0 = rightmost digit.

## Operation
- Input capture: i_data and disp_mode are registered every clk into i_data_q and mode_q.
- Prescaler: a DIV_BITS-bit free-running counter, div_cnt, increments every clk and wraps to 0.
- Scan counter: a 3-bit scan_idx increments (mod 8, 7→0) on every clk where div_cnt is all-ones.
- Digit enable: disp_an_o is registered each clk as ~(8'b1 << scan_idx). Exactly one digit is low at any time after reset.
- Hex mode (mode_q = 0):
  - Nibble n = i_data_q[4*scan_idx+3 : 4*scan_idx].
  - disp_seg_o = {1'b1 (dp off), hex_pattern(n)}.
  - Patterns (full 8-bit, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Raw mode (mode_q = 1):
  - For scan_idx 0–3, disp_seg_o = i_data_q[8*scan_idx+7 : 8*scan_idx], passed through unmodified (already active-low).
  - For scan_idx 4–7, disp_seg_o = 8'hFF (blank); the anode still sequences normally.
- Changes on i_data mid-scan take effect on the currently displayed digit; there is no frame-level latching.

## Timing
- Reset (async assert, sync-style release on the next clk edge after rstn goes high):
  - div_cnt = 0, scan_idx = 0, i_data_q = 0, mode_q = 0.
  - disp_an_o = 8'hFF (all digits off), disp_seg_o = 8'hFF (all segments off).
- First active output: on the first clk edge after release, disp_an_o = 8'hFE. On that same edge disp_seg_o = encode(i_data_q = 0) = 8'hC0; the real data appears one edge later.
- Latency:
  - i_data → disp_seg_o: 2 clk (capture register, then output register).
  - scan_idx change → disp_an_o and disp_seg_o: 1 clk. Anode and segments always change on the same edge and are never mismatched.
- Dwell per digit: exactly 2^DIV_BITS clk. Full frame: 8·2^DIV_BITS clk (2.62 ms at 100 MHz with the default).
- Reset asserted mid-frame: outputs go to FF/FF immediately, without waiting for clk. The scan restarts at digit 0.

## Structure
- Shared package (display_pkg):
  - localparam array of the 16 hex segment patterns.
  - Constants SEG_BLANK = 8'hFF and AN_OFF = 8'hFF.
- One natural sub-module: hex7seg_decode, a pure combinational 4-bit → 8-bit pattern decoder with dp forced to 1. It is instantiated once, fed by the scan mux.
- Everything else (prescaler, scan counter, capture and output registers) stays in seg7_x16.

## Test plan
Run all scenarios with DIV_BITS = 2 unless noted.
- Reset: hold rstn = 0 with clk running → disp_an_o = FF, disp_seg_o = FF. Assert rstn low asynchronously mid-frame → both outputs read FF before the next clk edge.
- Hex scan: i_data = 32'h76543210, disp_mode = 0, release reset → disp_an_o cycles FE, FD, FB, F7, EF, DF, BF, 7F, each for 4 clk. disp_seg_o tracks C0, F9, A4, B0, 99, 92, 82, F8, then wraps to FE / C0.
- Upper hex digits: i_data = 32'hFEDCBA98 → digits 0–7 show 80, 90, 88, 83, C6, A1, 86, 8E.
- Raw mode: disp_mode = 1, i_data = 32'h7F00_AA55 → digit 0 = 55, digit 1 = AA, digit 2 = 00, digit 3 = 7F, digits 4–7 = FF while the anodes still sequence.
- Data-change latency: during digit 0, change i_data[3:0] from 0 to 1 → disp_seg_o goes C0 → F9 exactly 2 clk later, and disp_an_o stays FE.
- Default divider: DIV_BITS = 15 → each anode stays low exactly 32768 clk, and the frame period is 262144 clk.
